// File: rtl/btn_pkg.sv
// Shared types and width helpers for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE_REL = 2'd0,
    WAIT_PRS = 2'd1,
    PRESSED  = 2'd2,
    WAIT_REL = 2'd3
  } db_state_t;

  function automatic int db_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  function automatic int long_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF sync, debounce FSM, edge ticks.
// Optional hold counter enabled by BTN_LONG_PRESS_EN.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DB_CYCLES   = 500000,
  parameter int LONG_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic p,
  output logic level,
  output logic press_tick,
  output logic release_tick,
  output logic long_tick
);

  localparam int CW = db_cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  db_state_t state;
  logic [CW-1:0] cnt;
  logic s1, s2, level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      state        <= IDLE_REL;
      cnt          <= '0;
      level        <= 1'b0;
      level_d      <= 1'b0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
    end else begin
      s1           <= p;
      s2           <= s1;
      level_d      <= level;
      press_tick   <= level & ~level_d;
      release_tick <= ~level & level_d;
      unique case (state)
        IDLE_REL: begin
          if (s2) begin
            state <= WAIT_PRS;
            cnt   <= ONE;
          end
        end
        WAIT_PRS: begin
          if (!s2) begin
            state <= IDLE_REL;
            cnt   <= '0;
          end else if (cnt == DB_MAX) begin
            state <= PRESSED;
            level <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        PRESSED: begin
          if (!s2) begin
            state <= WAIT_REL;
            cnt   <= ONE;
          end
        end
        WAIT_REL: begin
          if (s2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_MAX) begin
            state <= IDLE_REL;
            level <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE_REL;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int LW = long_cnt_w(LONG_CYCLES);
  localparam logic [LW-1:0] L_MAX = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] L_ONE = LW'(1);

  logic [LW-1:0] hold;

  // Saturates at L_MAX so a long hold yields one tick only.
  always_ff @(posedge clk) begin
    if (reset || !level) begin
      hold      <= '0;
      long_tick <= 1'b0;
    end else if (hold != L_MAX) begin
      hold      <= hold + L_ONE;
      long_tick <= (hold == L_MAX - L_ONE);
    end else begin
      long_tick <= 1'b0;
    end
  end
`else
  // Always 0; the term only keeps LONG_CYCLES referenced.
  assign long_tick = 1'b0 && (LONG_CYCLES != 0);
`endif

endmodule

// File: rtl/btn_conditioner_n.sv
// N-channel button front end: polarity fix plus per-channel conditioning.
// Long-press ticks are built only when BTN_LONG_PRESS_EN is defined.
module btn_conditioner_n
  import btn_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DB_CYCLES   = 500000,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int LONG_CYCLES = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_tick,
  output logic [N_CH-1:0] release_tick,
  output logic [N_CH-1:0] long_tick
);

  logic [N_CH-1:0] p;

  assign p = ACTIVE_LOW ? ~btn_raw : btn_raw;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    btn_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .p           (p[gi]),
      .level       (btn_level[gi]),
      .press_tick  (press_tick[gi]),
      .release_tick(release_tick[gi]),
      .long_tick   (long_tick[gi])
    );
  end

endmodule
